seletor_banco: RTL and testbench

Parametrised register bank that generalises the single hold-or-load byte selector into DEPTH addressable entries of WIDTH bits. Each entry keeps its value unless written, and a write either loads new data or adds it to the stored value. The bank also has a registered read port and a multi-cycle clear sequencer. It sits in the memory subsystem as the storage element behind the input/selection logic.

---
 rtl/seletor_banco.sv | 112 +++++++++++
 tb/tb_seletor_banco.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seletor_banco.sv
// Addressable bank of DEPTH hold-or-update entries (load or accumulate) with a clear sweep.
// Write stored at accepting edge; registered read, 1 cycle; busy/ovf registered.
// No backpressure: writes during a clear sweep, or alongside clr_start, are dropped; reads always served.
module seletor_banco #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_mode,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             clr_start,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t            state;
  logic [AW-1:0]     ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH:0]    sum;
  logic              wr_acc;
  logic              clr_we;

  // A start request takes precedence over a write issued in the same cycle.
  assign wr_acc = (state == IDLE) && wr_en && !clr_start;
  assign clr_we = (state == CLEAR);

  // One extra bit so the carry out of an accumulate is visible.
  assign sum = {1'b0, mem[wr_addr]} + {1'b0, wr_data};

  // Sweep sequencer: walks ptr over every entry once, busy mirrors the CLEAR state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          // clr_start is not looked at here, so a sweep never restarts.
          ptr <= ptr + 1'b1;
          if (ptr == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Entry storage: sweep zeroing, otherwise an accepted load or accumulate; all others hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_we) begin
      mem[ptr] <= '0;
    end else if (wr_acc) begin
      mem[wr_addr] <= wr_mode ? sum[WIDTH-1:0] : wr_data;
    end
  end

  // Carry flag pulses only in the cycle after an accepted accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= wr_acc && wr_mode && sum[WIDTH];
    end
  end

  // Registered read port; samples storage before this edge's update (read-before-write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_seletor_banco.sv
// Directed bench for seletor_banco (WIDTH=8, DEPTH=4) with a read-data scoreboard.
module tb_seletor_banco;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       wr_mode;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [1:0] rd_addr;
  logic       clr_start;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       ovf;

  int total;
  int bad;
  logic [7:0] exp_q [$];

  seletor_banco #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_mode   (wr_mode),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .clr_start (clr_start),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented read result is matched against the oldest expected value.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got 0x%0h with no read outstanding", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          bad++;
          $display("FAIL rd_data: got 0x%0h expected 0x%0h", rd_data, e);
        end
      end
    end
  end

  // Drive one cycle of stimulus; returns 1 time unit after the edge that samples it.
  task automatic drive(input logic we, input logic mode, input logic [1:0] wa,
                       input logic [7:0] wd, input logic re, input logic [1:0] ra,
                       input logic clr, input logic [7:0] exp_rd);
    wr_en = we; wr_mode = mode; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; clr_start = clr;
    if (re) exp_q.push_back(exp_rd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00);
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    drive(1'b1, 1'b0, a, d, 1'b0, 2'd0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, a, 1'b0, e);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    wr_en = 1'b0; wr_mode = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; clr_start = 1'b0;
    #12;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Async reset between edges after loading data.
    load(2'd0, 8'hAB);
    load(2'd3, 8'hCD);
    rd(2'd0, 8'hAB);
    idle();
    #1 rst = 1'b1;
    #1;
    check("async_rst_rd_data", rd_data, 0);
    check("async_rst_rd_valid", rd_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ovf", ovf, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) rd(2'(i), 8'h00);
    idle();

    // Load then read.
    load(2'd2, 8'h5A);
    rd(2'd2, 8'h5A);
    check("load_rd_valid", rd_valid, 1);
    rd(2'd0, 8'h00);
    rd(2'd1, 8'h00);
    rd(2'd3, 8'h00);
    idle();
    check("rd_valid_drops", rd_valid, 0);
    check("rd_data_holds", rd_data, 8'h00);

    // Accumulate with carry.
    load(2'd1, 8'hF0);
    check("ovf_after_load", ovf, 0);
    drive(1'b1, 1'b1, 2'd1, 8'h20, 1'b0, 2'd0, 1'b0, 8'h00);
    check("ovf_carry", ovf, 1);
    drive(1'b1, 1'b1, 2'd1, 8'h01, 1'b0, 2'd0, 1'b0, 8'h00);
    check("ovf_no_carry", ovf, 0);
    rd(2'd1, 8'h11);
    check("ovf_idle", ovf, 0);

    // Read-before-write on the same address.
    load(2'd3, 8'h11);
    drive(1'b1, 1'b0, 2'd3, 8'h22, 1'b1, 2'd3, 1'b0, 8'h11);
    rd(2'd3, 8'h22);
    idle();

    // Clear sweep.
    for (int i = 0; i < 4; i++) load(2'(i), 8'(i + 1));
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 8'h00);        // E0
    check("busy_c1", busy, 1);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0, 8'h01);        // E1: entry 0 cleared, old value read
    check("busy_c2", busy, 1);
    drive(1'b1, 1'b0, 2'd0, 8'h77, 1'b1, 2'd1, 1'b1, 8'h02);        // E2: dropped write, ignored restart
    check("busy_c3", busy, 1);
    drive(1'b1, 1'b1, 2'd3, 8'hFF, 1'b0, 2'd0, 1'b0, 8'h00);        // E3: dropped add would carry
    check("busy_c4", busy, 1);
    check("ovf_dropped_add", ovf, 0);
    idle();                                                          // E4
    check("busy_done", busy, 0);
    load(2'd2, 8'h99);                                               // first non-busy cycle
    check("busy_stays_low", busy, 0);
    rd(2'd0, 8'h00);
    rd(2'd1, 8'h00);
    rd(2'd2, 8'h99);
    rd(2'd3, 8'h00);
    idle();

    // Reset during the second busy cycle.
    for (int i = 0; i < 4; i++) load(2'(i), 8'h40 + 8'(i));
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 8'h00);
    idle();
    check("busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_clear_rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) rd(2'(i), 8'h00);
    load(2'd2, 8'h3C);
    rd(2'd2, 8'h3C);
    idle();
    idle();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
